// File: rtl/uart_tx_frame_gen_pkg.sv
// Shared types and constants for the UART frame transmitter.
package uart_pkg;

   // Frame FSM states in line order.
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_e;

   localparam logic PAR_EVEN  = 1'b0;
   localparam logic PAR_ODD   = 1'b1;
   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;

   // Widest payload the transmitter supports; narrower words are zero-extended.
   localparam int MAX_DATA_WIDTH = 9;

   // Parity bit for a payload: even -> XOR-reduce, odd -> inverted XOR-reduce.
   // Zero-extension does not change the XOR-reduce, so narrow words are safe.
   function automatic logic frame_parity(input logic [MAX_DATA_WIDTH-1:0] data,
                                         input logic par_typ);
      return (par_typ == PAR_ODD) ? ~(^data) : (^data);
   endfunction

endpackage

// File: rtl/uart_tx_frame_gen_if.sv
// Word-in / serial-out bundle between the TX FIFO read side and the transmitter.
interface uart_tx_frame_gen_if #(
   parameter int DATA_WIDTH = 8,
   parameter int DIV_WIDTH  = 16
);
   logic [DATA_WIDTH-1:0] p_data;
   logic                  data_valid;
   logic                  par_en;
   logic                  par_typ;
   logic                  stop_2;
   logic [DIV_WIDTH-1:0]  baud_div;
   logic                  data_ack;
   logic                  busy;
   logic                  tx_out;

   // The word source drives the request side and observes the line.
   modport master (
      output p_data, data_valid, par_en, par_typ, stop_2, baud_div,
      input  data_ack, busy, tx_out
   );

   // The transmitter consumes the request side and drives the line.
   modport slave (
      input  p_data, data_valid, par_en, par_typ, stop_2, baud_div,
      output data_ack, busy, tx_out
   );
endinterface

// File: rtl/uart_tx_frame_gen_baud_tick.sv
// Bit-time counter: counts 0..div-1 while enabled, pulses wrap_o on the last cycle.
module uart_baud_tick #(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr_i,
   input  logic                 en_i,
   input  logic [DIV_WIDTH-1:0] div_i,
   output logic                 wrap_o
);

   logic [DIV_WIDTH-1:0] cnt_q;
   logic [DIV_WIDTH-1:0] cnt_d;

   // div_i is always >= 1, so div_i - 1 never underflows.
   assign wrap_o = en_i && (cnt_q == (div_i - DIV_WIDTH'(1)));

   // Next count: restart on a new frame, otherwise step and wrap.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = wrap_o ? '0 : (cnt_q + DIV_WIDTH'(1));
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_frame_gen.sv
// UART transmitter: one word per handshake, start/data/parity/stop frame on tx_out.
module uart_tx_frame_gen
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                clk,
   input  logic                rst,
   uart_tx_frame_gen_if.slave  bus
);

   localparam int CNT_W = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_WIDTH - 1);

   uart_state_e           state_q;
   logic [CNT_W-1:0]      bit_idx_q;   // data bit index in DATA, stop bit index in STOP
   logic [DATA_WIDTH-1:0] shift_q;
   logic                  parity_q;
   logic                  par_en_q;
   logic                  stop_2_q;
   logic [DIV_WIDTH-1:0]  div_q;
   logic                  tx_q;
   logic                  busy_q;
   logic                  ack_q;

   logic                  bit_wrap;
   logic                  last_stop;
   logic                  accept;
   logic [DIV_WIDTH-1:0]  eff_div;

   // A divisor of 0 behaves as 1 so the bit counter always has a valid range.
   assign eff_div   = (bus.baud_div == '0) ? DIV_WIDTH'(1) : bus.baud_div;
   assign last_stop = (state_q == STOP) && bit_wrap &&
                      (!stop_2_q || (bit_idx_q == CNT_W'(1)));
   // Accept from IDLE, or in the final stop-bit cycle for gapless back-to-back frames.
   assign accept    = bus.data_valid && ((state_q == IDLE) || last_stop);

   uart_baud_tick #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_baud_tick (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (accept),
      .en_i   (state_q != IDLE),
      .div_i  (div_q),
      .wrap_o (bit_wrap)
   );

   // Frame FSM with registered line, busy and acknowledge outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         bit_idx_q <= '0;
         shift_q   <= '0;
         parity_q  <= 1'b0;
         par_en_q  <= 1'b0;
         stop_2_q  <= 1'b0;
         div_q     <= DIV_WIDTH'(1);
         tx_q      <= LINE_IDLE;
         busy_q    <= 1'b0;
         ack_q     <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         if (accept) begin
            state_q   <= START;
            bit_idx_q <= '0;
            shift_q   <= bus.p_data;
            parity_q  <= frame_parity(MAX_DATA_WIDTH'(bus.p_data), bus.par_typ);
            par_en_q  <= bus.par_en;
            stop_2_q  <= bus.stop_2;
            div_q     <= eff_div;
            tx_q      <= START_BIT;
            busy_q    <= 1'b1;
            ack_q     <= 1'b1;
         end else if (bit_wrap) begin
            case (state_q)
               START: begin
                  state_q   <= DATA;
                  bit_idx_q <= '0;
                  tx_q      <= shift_q[0];
                  shift_q   <= shift_q >> 1;
               end
               DATA: begin
                  if (bit_idx_q == LAST_DATA) begin
                     bit_idx_q <= '0;
                     if (par_en_q) begin
                        state_q <= PARITY;
                        tx_q    <= parity_q;
                     end else begin
                        state_q <= STOP;
                        tx_q    <= LINE_IDLE;
                     end
                  end else begin
                     bit_idx_q <= bit_idx_q + CNT_W'(1);
                     tx_q      <= shift_q[0];
                     shift_q   <= shift_q >> 1;
                  end
               end
               PARITY: begin
                  state_q   <= STOP;
                  bit_idx_q <= '0;
                  tx_q      <= LINE_IDLE;
               end
               STOP: begin
                  if (!stop_2_q || (bit_idx_q == CNT_W'(1))) begin
                     state_q   <= IDLE;
                     bit_idx_q <= '0;
                     busy_q    <= 1'b0;
                     tx_q      <= LINE_IDLE;
                  end else begin
                     bit_idx_q <= CNT_W'(1);
                  end
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign bus.tx_out   = tx_q;
   assign bus.busy     = busy_q;
   assign bus.data_ack = ack_q;

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Scoreboard bench: stimulus queues hand-computed frames, a monitor checks the line.
module tb_uart_tx_frame_gen;

   logic clk;
   logic rst;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [15:0] bits;      // bit i = i-th bit on the line (start bit first)
      int          nbits;
      int          d;         // effective cycles per bit
      bit          b2b_next;  // next frame starts right after this one
      bit          abort;     // frame is cut short by reset
   } exp_t;

   exp_t sb_q[$];

   uart_tx_frame_gen_if #(.DATA_WIDTH(8), .DIV_WIDTH(16)) bus ();

   uart_tx_frame_gen #(
      .DATA_WIDTH (8),
      .DIV_WIDTH  (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check1(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %b required %b", name, act, req);
      end
      else $display("check %s: %b ok", name, act);
   endtask

   task automatic expect_frame(input string name, input logic [15:0] bits,
                               input int nbits, input int d,
                               input bit b2b, input bit abort);
      exp_t e;
      e.name = name; e.bits = bits; e.nbits = nbits; e.d = d;
      e.b2b_next = b2b; e.abort = abort;
      sb_q.push_back(e);
   endtask

   task automatic drive(input logic [7:0] w, input logic pe, input logic pt,
                        input logic s2, input logic [15:0] div);
      bus.p_data   = w;
      bus.par_en   = pe;
      bus.par_typ  = pt;
      bus.stop_2   = s2;
      bus.baud_div = div;
   endtask

   task automatic wait_ack(input string name, input int limit);
      bit seen = 0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (bus.data_ack === 1'b1) begin
            seen = 1;
            break;
         end
      end
      check1({name, "_ack_seen"}, seen, 1'b1);
   endtask

   task automatic wait_idle(input string name);
      bit idle = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (bus.busy === 1'b0) begin
            idle = 1;
            break;
         end
      end
      check1({name, "_idle_reached"}, idle, 1'b1);
   endtask

   // Monitor: every data_ack marks the first start-bit cycle of a frame.
   initial begin : monitor
      exp_t e;
      bit   aborted;
      int   b;
      forever begin
         @(negedge clk);
         while (!rst && bus.data_ack === 1'b1) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ack: data_ack=1 required 0 (no frame pending)");
               @(negedge clk);
            end else begin
               e = sb_q.pop_front();
               aborted = 0;
               for (int k = 0; k < e.nbits * e.d; k++) begin
                  if (k > 0) @(negedge clk);
                  if (rst) begin
                     aborted = 1;
                     break;
                  end
                  b = k / e.d;
                  checks++;
                  if (bus.tx_out !== e.bits[b] || bus.busy !== 1'b1 ||
                      bus.data_ack !== 1'(k == 0)) begin
                     errors++;
                     $display("FAIL %s cycle %0d bit %0d: tx=%b busy=%b ack=%b required tx=%b busy=1 ack=%b",
                              e.name, k, b, bus.tx_out, bus.busy, bus.data_ack,
                              e.bits[b], 1'(k == 0));
                  end
               end
               checks++;
               if (aborted != e.abort) begin
                  errors++;
                  $display("FAIL %s_abort: aborted=%0d required %0d", e.name, aborted, e.abort);
               end
               if (aborted) break;
               $display("frame %s: %0d bits x %0d cycles checked", e.name, e.nbits, e.d);
               @(negedge clk);
               checks++;
               if (bus.data_ack !== e.b2b_next) begin
                  errors++;
                  $display("FAIL %s_next_ack: ack=%b required %b", e.name, bus.data_ack, e.b2b_next);
               end
               if (bus.data_ack !== 1'b1) begin
                  checks++;
                  if (bus.busy !== 1'b0 || bus.tx_out !== 1'b1) begin
                     errors++;
                     $display("FAIL %s_end_idle: busy=%b tx=%b required busy=0 tx=1",
                              e.name, bus.busy, bus.tx_out);
                  end
               end
            end
         end
      end
   end

   // Directed stimulus.
   initial begin : stimulus
      rst = 1'b1;
      bus.data_valid = 1'b0;
      drive(8'h00, 1'b0, 1'b0, 1'b0, 16'd1);
      repeat (3) @(negedge clk);
      check1("reset_tx", bus.tx_out, 1'b1);
      check1("reset_busy", bus.busy, 1'b0);
      check1("reset_ack", bus.data_ack, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check1("post_reset_tx", bus.tx_out, 1'b1);

      // Even parity, 0xAA, D=4.
      expect_frame("even_aa", 16'b10101010100, 11, 4, 0, 0);
      drive(8'hAA, 1'b1, 1'b0, 1'b0, 16'd4);
      bus.data_valid = 1'b1;
      wait_ack("even_aa", 5);
      bus.data_valid = 1'b0;
      wait_idle("even_aa");

      // Odd parity, 0x8E, D=8.
      expect_frame("odd_8e", 16'b11100011100, 11, 8, 0, 0);
      drive(8'h8E, 1'b1, 1'b1, 1'b0, 16'd8);
      bus.data_valid = 1'b1;
      wait_ack("odd_8e", 5);
      bus.data_valid = 1'b0;
      wait_idle("odd_8e");

      // No parity, two stop bits, divisor 0 behaves as 1.
      expect_frame("stop2_3c", 16'b11001111000, 11, 1, 0, 0);
      drive(8'h3C, 1'b0, 1'b0, 1'b1, 16'd0);
      bus.data_valid = 1'b1;
      wait_ack("stop2_3c", 5);
      bus.data_valid = 1'b0;
      wait_idle("stop2_3c");

      // Back-to-back with data_valid held high.
      expect_frame("b2b_55", 16'b1010101010, 10, 2, 1, 0);
      expect_frame("b2b_c3", 16'b1110000110, 10, 2, 0, 0);
      drive(8'h55, 1'b0, 1'b0, 1'b0, 16'd2);
      bus.data_valid = 1'b1;
      wait_ack("b2b_55", 5);
      bus.p_data = 8'hC3;
      wait_ack("b2b_c3", 60);
      bus.data_valid = 1'b0;
      wait_idle("b2b_c3");

      // Reset in the middle of data bit 3 (line bit 4, cycle 17 at D=4).
      expect_frame("rst_f0", 16'b1111100000, 10, 4, 0, 1);
      drive(8'hF0, 1'b0, 1'b0, 1'b0, 16'd4);
      bus.data_valid = 1'b1;
      wait_ack("rst_f0", 5);
      bus.data_valid = 1'b0;
      repeat (17) @(negedge clk);
      check1("pre_rst_tx", bus.tx_out, 1'b0);
      check1("pre_rst_busy", bus.busy, 1'b1);
      #2 rst = 1'b1;
      #1;
      check1("async_rst_tx", bus.tx_out, 1'b1);
      check1("async_rst_busy", bus.busy, 1'b0);
      check1("async_rst_ack", bus.data_ack, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Full frame after reset: 0x0F, odd parity, two stops, D=3.
      expect_frame("after_rst_0f", 16'b111000011110, 12, 3, 0, 0);
      drive(8'h0F, 1'b1, 1'b1, 1'b1, 16'd3);
      bus.data_valid = 1'b1;
      wait_ack("after_rst_0f", 5);
      bus.data_valid = 1'b0;
      wait_idle("after_rst_0f");

      // Inputs change mid-frame; the frame keeps its latched settings.
      expect_frame("stable_6b", 16'b11011010110, 11, 5, 0, 0);
      drive(8'h6B, 1'b1, 1'b0, 1'b0, 16'd5);
      bus.data_valid = 1'b1;
      wait_ack("stable_6b", 5);
      bus.data_valid = 1'b0;
      repeat (7) @(negedge clk);
      drive(8'hFF, 1'b0, 1'b1, 1'b1, 16'd2);
      wait_idle("stable_6b");

      for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d frames pending required 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
